// File: rtl/lcd_pkg.sv
// Shared HD44780 read-engine definitions: FSM state encoding, status-byte fields and RS codes.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HI,
        ST_HOLD,
        ST_GAP,
        ST_TURN
    } lcd_rd_state_e;

    localparam int unsigned BF_BIT    = 7;
    localparam int unsigned AC_MSB    = 6;
    localparam int unsigned AC_LSB    = 0;
    localparam logic        RS_STATUS = 1'b0;
    localparam logic        RS_DATA   = 1'b1;

    // Phase timers count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [15:0] phase_reload(input int unsigned cyc);
        return 16'(cyc - 1);
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Host-side request/response bundle of the LCD read engine.
interface lcd_bus_reader_if;
    logic       req;
    logic       rs_sel;
    logic       wait_nb;
    logic       ready;
    logic       done;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic       timeout;

    modport master (
        output req, rs_sel, wait_nb,
        input  ready, done, rd_data, busy_flag, timeout
    );

    modport slave (
        input  req, rs_sel, wait_nb,
        output ready, done, rd_data, busy_flag, timeout
    );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable 16-bit down-counter; expire is high while the count sits at zero.
module lcd_phase_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        expire
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle engine: status/busy polling and data reads, owning DB turnaround.
// Defining LCD_RD_TIMEOUT_EN bounds busy polling to TIMEOUT_POLLS samples.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned E_HIGH_CYC   = 5,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned POLL_GAP_CYC = 4
`ifdef LCD_RD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_POLLS = 1000
`endif
) (
    input  logic            clk,
    input  logic            rst,
    lcd_bus_reader_if.slave host,
    input  logic [7:0]      db_in,
    output logic            db_oe,
    output logic            LCD_RS,
    output logic            LCD_RW,
    output logic            LCD_E
);

    lcd_rd_state_e state_q, state_d;
    logic          rs_q, rs_d;
    logic          wait_q, wait_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          bf_q, bf_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          ready;
    logic          phase_load;
    logic [15:0]   phase_val;
    logic          phase_expire;
    logic          poll_abort;

`ifdef LCD_RD_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        if (state_q == ST_IDLE && host.req) begin
            poll_cnt_d = '0;
        end else if (state_q == ST_E_HI && phase_expire && wait_q && db_in[BF_BIT]) begin
            poll_cnt_d = poll_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign poll_abort = wait_q && bf_q && (poll_cnt_q >= 16'(TIMEOUT_POLLS));
`else
    assign poll_abort = 1'b0;
`endif

    lcd_phase_timer u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (phase_val),
        .expire   (phase_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rs_q      <= RS_STATUS;
            wait_q    <= 1'b0;
            rd_data_q <= '0;
            bf_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rs_q      <= rs_d;
            wait_q    <= wait_d;
            rd_data_q <= rd_data_d;
            bf_q      <= bf_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rs_d      = rs_q;
        wait_d    = wait_q;
        rd_data_d = rd_data_q;
        bf_d      = bf_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.req) begin
                    state_d = ST_SETUP;
                    rs_d    = host.rs_sel;
                    wait_d  = host.wait_nb && (host.rs_sel == RS_STATUS);
                end
            end
            ST_SETUP: begin
                if (phase_expire) state_d = ST_E_HI;
            end
            ST_E_HI: begin
                if (phase_expire) begin
                    state_d   = ST_HOLD;
                    rd_data_d = db_in;
                    if (rs_q == RS_STATUS) bf_d = db_in[BF_BIT];
                end
            end
            ST_HOLD: begin
                if (phase_expire) begin
                    state_d = (wait_q && bf_q && !poll_abort) ? ST_GAP : ST_TURN;
                end
            end
            ST_GAP: begin
                if (phase_expire) state_d = ST_SETUP;
            end
            ST_TURN: begin
                state_d   = ST_IDLE;
                done_d    = 1'b1;
                timeout_d = poll_abort;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every state change restarts the shared timer with the length of the phase being entered.
    always_comb begin
        phase_load = (state_d != state_q);
        case (state_d)
            ST_SETUP: phase_val = phase_reload(SETUP_CYC);
            ST_E_HI:  phase_val = phase_reload(E_HIGH_CYC);
            ST_HOLD:  phase_val = phase_reload(HOLD_CYC);
            ST_GAP:   phase_val = phase_reload(POLL_GAP_CYC);
            default:  phase_val = '0;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        db_oe  = 1'b0;
        LCD_E  = 1'b0;
        LCD_RW = 1'b0;
        LCD_RS = rs_q;
        case (state_q)
            ST_IDLE: begin
                ready  = 1'b1;
                db_oe  = 1'b1;
                LCD_RS = RS_STATUS;
            end
            ST_E_HI: begin
                LCD_E  = 1'b1;
                LCD_RW = 1'b1;
            end
            ST_SETUP, ST_HOLD, ST_GAP: LCD_RW = 1'b1;
            default: ;
        endcase
    end

    assign host.ready     = ready;
    assign host.done      = done_q;
    assign host.rd_data   = rd_data_q;
    assign host.busy_flag = bf_q;
    assign host.timeout   = timeout_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader; expected read results flow through a scoreboard queue.
module tb_lcd_bus_reader;

    localparam int S    = 2;
    localparam int EH   = 5;
    localparam int H    = 2;
    localparam int G    = 4;
    localparam int LAT  = S + EH + H + 1;
    localparam int POLL = G + S + EH + H;
    localparam int BUDGET = 200;
`ifdef LCD_RD_TIMEOUT_EN
    localparam int WAIT_BUSY = 2;
`else
    localparam int WAIT_BUSY = 3;
`endif

    typedef struct {
        logic [7:0] data;
        logic       bf;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] db_in;
    logic       db_oe;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;

    lcd_bus_reader_if host ();

    lcd_bus_reader #(
        .SETUP_CYC    (S),
        .E_HIGH_CYC   (EH),
        .HOLD_CYC     (H),
        .POLL_GAP_CYC (G)
`ifdef LCD_RD_TIMEOUT_EN
        ,
        .TIMEOUT_POLLS(3)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .host   (host.slave),
        .db_in  (db_in),
        .db_oe  (db_oe),
        .LCD_RS (LCD_RS),
        .LCD_RW (LCD_RW),
        .LCD_E  (LCD_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t e;
    logic model_bf = 1'b0;

    int   obs_done_cyc, obs_pulses, obs_first_rise, obs_ehi_bad, obs_gap_bad;
    int   obs_rw_cnt, obs_oe0_cnt, obs_oe_viol, obs_rs_bad;
    logic obs_ready0;

    task automatic issue(input logic rs, input logic wn, input bit hold);
        @(negedge clk);
        host.req     = 1'b1;
        host.rs_sel  = rs;
        host.wait_nb = wn;
        @(posedge clk);
        #1;
        if (!hold) host.req = 1'b0;
    endtask

    // Starts on the cycle after the accept edge (c=0) and returns in the done cycle.
    task automatic observe(input logic rs, input logic [7:0] busy_byte, input int n_busy,
                           input logic [7:0] final_byte, input bit noise);
        logic prev_e;
        int   ehi_len;
        int   elo_len;
        prev_e = 1'b0; ehi_len = 0; elo_len = 0;
        obs_done_cyc = -1; obs_pulses = 0; obs_first_rise = -1; obs_ehi_bad = 0;
        obs_gap_bad = 0; obs_rw_cnt = 0; obs_oe0_cnt = 0; obs_oe_viol = 0; obs_rs_bad = 0;
        obs_ready0 = host.ready;
        db_in = (n_busy > 0) ? busy_byte : final_byte;
        for (int c = 0; c < BUDGET; c++) begin
            if (LCD_E) begin
                if (!prev_e) begin
                    if (obs_first_rise < 0) obs_first_rise = c;
                    // E-low stretch between pulses spans HOLD, GAP and SETUP.
                    if (obs_pulses > 0 && elo_len != H + G + S) obs_gap_bad++;
                end
                ehi_len++;
            end else begin
                if (prev_e) begin
                    obs_pulses++;
                    if (ehi_len != EH) obs_ehi_bad++;
                    ehi_len = 0;
                    elo_len = 0;
                end
                elo_len++;
            end
            if (LCD_RW) begin
                obs_rw_cnt++;
                if (db_oe) obs_oe_viol++;
                if (LCD_RS !== rs) obs_rs_bad++;
            end
            if (!db_oe) obs_oe0_cnt++;
            prev_e = LCD_E;
            if (host.done === 1'b1) begin
                obs_done_cyc = c;
                break;
            end
            db_in = (obs_pulses < n_busy) ? busy_byte : final_byte;
            if (noise) begin
                if (c == 3) begin
                    host.req = 1'b1; host.rs_sel = ~rs; host.wait_nb = 1'b1;
                end
                if (c == 6) host.req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({LCD_E, LCD_RW, LCD_RS, db_oe, host.ready, host.done, host.timeout, host.busy_flag} !== 8'b0001_1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00011000",
                     {LCD_E, LCD_RW, LCD_RS, db_oe, host.ready, host.done, host.timeout, host.busy_flag});
        end
        checks++;
        if (host.rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_rd_data: got %h expected 00", host.rd_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({host.ready, db_oe, LCD_RW} !== 3'b110) begin
            errors++; $display("FAIL reset_idle: got %b expected 110", {host.ready, db_oe, LCD_RW});
        end
    endtask

    task automatic test_status_read();
        model_bf = 1'b1;
        sb_q.push_back('{data: 8'h85, bf: 1'b1, to: 1'b0});
        issue(1'b0, 1'b0, 1'b0);
        observe(1'b0, 8'h00, 0, 8'h85, 1'b0);
        checks++;
        if (obs_done_cyc !== LAT) begin errors++; $display("FAIL status_latency: got %0d expected %0d", obs_done_cyc, LAT); end
        checks++;
        if (obs_ready0 !== 1'b0) begin errors++; $display("FAIL status_ready_drop: got %b expected 0", obs_ready0); end
        checks++;
        if (obs_first_rise !== S) begin errors++; $display("FAIL status_e_rise: got %0d expected %0d", obs_first_rise, S); end
        checks++;
        if (obs_pulses !== 1 || obs_ehi_bad !== 0) begin
            errors++; $display("FAIL status_e_pulse: got pulses=%0d bad_width=%0d expected 1 and 0", obs_pulses, obs_ehi_bad);
        end
        checks++;
        if (obs_rw_cnt !== S + EH + H || obs_oe0_cnt !== S + EH + H + 1 || obs_oe_viol !== 0) begin
            errors++; $display("FAIL status_turnaround: got rw=%0d oe0=%0d viol=%0d expected %0d %0d 0",
                               obs_rw_cnt, obs_oe0_cnt, obs_oe_viol, S + EH + H, S + EH + H + 1);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL status_sb: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL status_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({host.done, host.ready} !== 2'b01) begin
            errors++; $display("FAIL status_done_pulse: got %b expected 01", {host.done, host.ready});
        end
    endtask

    task automatic test_data_read();
        sb_q.push_back('{data: 8'h41, bf: model_bf, to: 1'b0});
        issue(1'b1, 1'b1, 1'b0);
        observe(1'b1, 8'h00, 0, 8'h41, 1'b0);
        checks++;
        if (obs_done_cyc !== LAT || obs_pulses !== 1) begin
            errors++; $display("FAIL data_single_pulse: got done=%0d pulses=%0d expected %0d and 1", obs_done_cyc, obs_pulses, LAT);
        end
        checks++;
        if (obs_rs_bad !== 0) begin errors++; $display("FAIL data_rs: got %0d bad cycles expected 0", obs_rs_bad); end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL data_sb: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL data_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
    endtask

    task automatic test_wait_nb();
        model_bf = 1'b0;
        sb_q.push_back('{data: 8'h12, bf: 1'b0, to: 1'b0});
        issue(1'b0, 1'b1, 1'b0);
        observe(1'b0, 8'h80, WAIT_BUSY, 8'h12, 1'b0);
        checks++;
        if (obs_pulses !== WAIT_BUSY + 1) begin
            errors++; $display("FAIL wait_pulses: got %0d expected %0d", obs_pulses, WAIT_BUSY + 1);
        end
        checks++;
        if (obs_gap_bad !== 0 || obs_ehi_bad !== 0 || obs_oe_viol !== 0) begin
            errors++; $display("FAIL wait_spacing: got gap_bad=%0d width_bad=%0d oe_viol=%0d expected 0 0 0",
                               obs_gap_bad, obs_ehi_bad, obs_oe_viol);
        end
        checks++;
        if (obs_done_cyc !== LAT + WAIT_BUSY * POLL) begin
            errors++; $display("FAIL wait_latency: got %0d expected %0d", obs_done_cyc, LAT + WAIT_BUSY * POLL);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL wait_sb: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL wait_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
    endtask

    task automatic test_ignore_req();
        model_bf = 1'b1;
        sb_q.push_back('{data: 8'hC7, bf: 1'b1, to: 1'b0});
        issue(1'b0, 1'b0, 1'b0);
        observe(1'b0, 8'h00, 0, 8'hC7, 1'b1);
        host.rs_sel = 1'b0;
        host.wait_nb = 1'b0;
        checks++;
        if (obs_pulses !== 1 || obs_rs_bad !== 0 || obs_done_cyc !== LAT) begin
            errors++; $display("FAIL ignore_mid_req: got pulses=%0d rs_bad=%0d done=%0d expected 1 0 %0d",
                               obs_pulses, obs_rs_bad, obs_done_cyc, LAT);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL ignore_sb: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL ignore_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({host.ready, LCD_RW} !== 2'b10) begin
                errors++; $display("FAIL ignore_not_queued: got %b expected 10 at cycle %0d", {host.ready, LCD_RW}, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        model_bf = 1'b0;
        sb_q.push_back('{data: 8'h05, bf: 1'b0, to: 1'b0});
        sb_q.push_back('{data: 8'h7F, bf: 1'b0, to: 1'b0});
        issue(1'b0, 1'b0, 1'b1);
        observe(1'b0, 8'h00, 0, 8'h05, 1'b0);
        checks++;
        if (obs_done_cyc !== LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", obs_done_cyc, LAT); end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL b2b_first_sb: got empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL b2b_first_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
        @(posedge clk);
        #1;
        host.req = 1'b0;
        checks++;
        if ({host.ready, LCD_RW, db_oe} !== 3'b010) begin
            errors++; $display("FAIL b2b_second_setup: got %b expected 010", {host.ready, LCD_RW, db_oe});
        end
        observe(1'b0, 8'h00, 0, 8'h7F, 1'b0);
        checks++;
        if (obs_done_cyc !== LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", obs_done_cyc, LAT); end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL b2b_second_sb: got empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL b2b_second_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
    endtask

    task automatic test_reset_mid();
        db_in = 8'hFF;
        issue(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (LCD_E !== 1'b1) begin errors++; $display("FAIL rstmid_in_e_hi: got E=%b expected 1", LCD_E); end
        rst = 1'b0;
        #1;
        checks++;
        if ({LCD_E, LCD_RW, db_oe, host.ready} !== 4'b0011) begin
            errors++; $display("FAIL rstmid_async: got %b expected 0011", {LCD_E, LCD_RW, db_oe, host.ready});
        end
        checks++;
        if ({host.rd_data, host.busy_flag} !== 9'h000) begin
            errors++; $display("FAIL rstmid_regs: got %h/%b expected 00/0", host.rd_data, host.busy_flag);
        end
        @(negedge clk);
        rst = 1'b1;
        model_bf = 1'b0;
        sb_q.push_back('{data: 8'h33, bf: 1'b0, to: 1'b0});
        issue(1'b0, 1'b0, 1'b0);
        observe(1'b0, 8'h00, 0, 8'h33, 1'b0);
        checks++;
        if (obs_done_cyc !== LAT || obs_pulses !== 1) begin
            errors++; $display("FAIL rstmid_clean_read: got done=%0d pulses=%0d expected %0d and 1", obs_done_cyc, obs_pulses, LAT);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL rstmid_sb: got empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL rstmid_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
    endtask

`ifdef LCD_RD_TIMEOUT_EN
    task automatic test_timeout();
        model_bf = 1'b1;
        sb_q.push_back('{data: 8'h80, bf: 1'b1, to: 1'b1});
        issue(1'b0, 1'b1, 1'b0);
        observe(1'b0, 8'h80, 1000, 8'h80, 1'b0);
        checks++;
        if (obs_pulses !== 3 || obs_done_cyc !== LAT + 2 * POLL) begin
            errors++; $display("FAIL timeout_polls: got pulses=%0d done=%0d expected 3 and %0d",
                               obs_pulses, obs_done_cyc, LAT + 2 * POLL);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL timeout_sb: got empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            if ({host.rd_data, host.busy_flag, host.timeout} !== {e.data, e.bf, e.to}) begin
                errors++; $display("FAIL timeout_sb: got %h/%b/%b expected %h/%b/%b",
                                   host.rd_data, host.busy_flag, host.timeout, e.data, e.bf, e.to);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        db_in = 8'h00;
        host.req = 1'b0;
        host.rs_sel = 1'b0;
        host.wait_nb = 1'b0;
        test_reset();
        test_status_read();
        test_data_read();
        test_wait_nb();
        test_ignore_req();
        test_back_to_back();
        test_reset_mid();
`ifdef LCD_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
